sbmips_stack: RTL
=================

# sbmips_stack

Parametrised operand stack for the next-generation stack-based multi-cycle processor. It replaces the fixed push/pop/top-of-stack path with a configurable-width, configurable-depth stack. The stack executes one stack opcode per cycle, including an atomic pop-two/push-one for binary ALU results, DUP and SWAP. It exposes top (TOS) and next (NOS) operands combinationally and reports occupancy and sticky overflow/underflow errors to the control unit.

## Interface
- DATA_W, 8, operand width in bits (≥1)
- DEPTH, 16, number of entries (power of two, ≥2)
- CNT_W, $clog2(DEPTH)+1, derived width of `count`; not overridden
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- op  input  3  stack opcode, sampled on each rising edge
- din  input  DATA_W  value for PUSH, or ALU result for POP2PUSH
- tos  output  DATA_W  top entry; 0 when count==0
- nos  output  DATA_W  second entry; 0 when count<2
- count  output  CNT_W  number of valid entries, 0..DEPTH
- empty  output  1  count==0
- full  output  1  count==DEPTH
- overflow  output  1  sticky: an illegal grow was attempted
- underflow  output  1  sticky: an illegal shrink or read was attempted

## Operation
- Opcodes:
  - 0 NOP
  - 1 PUSH
  - 2 POP
  - 3 POP2PUSH
  - 4 DUP
  - 5 SWAP
  - 6 FLUSH
  - 7 CLRERR
- Stack pointer `sp` equals `count`. Entry k sits at mem[k]. TOS is mem[sp-1] and NOS is mem[sp-2].
- PUSH: mem[sp]←din, sp+1. Requires !full.
- POP: sp−1. Requires count≥1. The popped value is the pre-edge `tos`.
- POP2PUSH: mem[sp-2]←din, sp−1. Requires count≥2. The control unit drives din = ALU(nos, tos) in the same cycle.
- DUP: mem[sp]←mem[sp-1], sp+1. Requires count≥1 and !full.
- SWAP: exchanges mem[sp-1] and mem[sp-2]. sp is unchanged. Requires count≥2.
- FLUSH: sp←0. Storage is untouched. Flags are unchanged.
- CLRERR: clears overflow and underflow. Stack is unchanged.
- Illegal op (precondition false): no change to sp or storage. The matching flag is set.
  - PUSH on full sets overflow.
  - DUP on empty sets underflow.
  - DUP on full (count≥1) sets overflow.
  - POP, POP2PUSH or SWAP with too few entries sets underflow.
- Flags are sticky. Only CLRERR or reset clears them. A flag set in the same cycle as CLRERR cannot occur, because the ops are mutually exclusive.
- The sp arithmetic never wraps. count stays in 0..DEPTH at all times.
- Storage is not reset. tos and nos are gated to 0 whenever their entry is invalid, so X is never visible on the outputs.

## Timing
- Reset (rst low, asynchronous):
  - count=0, empty=1, full=0, overflow=0, underflow=0, tos=0, nos=0.
  - Reset asserted mid-operation discards the op in flight.
  - Deassertion is synchronised externally. The first op is sampled on the first rising edge with rst high.
- Every op completes in one cycle.
  - The state update happens at the rising edge.
  - tos, nos, count, empty, full and the flags are combinational from registers. They show the post-op state immediately after that edge.
- Read latency is zero. tos and nos are valid in the same cycle as the state they describe, so the control unit can compute ALU(nos, tos) and issue POP2PUSH in that cycle.
- Back-to-back ops are legal every cycle with no bubbles. Example: PUSH, PUSH, POP2PUSH on consecutive edges.

## Structure
- Shared package `sbmips_pkg` holds:
  - the `stack_op_t` enum (3-bit, opcode encodings above)
  - the DATA_W default constant, shared with the datapath
- One sub-module, `stack_regfile`:
  - DEPTH×DATA_W register array
  - two asynchronous read ports (sp-1, sp-2)
  - one synchronous write port plus a second write port, needed for SWAP
  - no reset on the array
- The top level holds the sp/count register, precondition decode, flag logic and output gating.

## Test plan
- Reset: hold rst low for 2 cycles, then release. Required: count=0, empty=1, tos=0, nos=0, both flags 0. Asserting rst asynchronously mid-sequence clears count within the same cycle.
- Push/pop order (DATA_W=8, DEPTH=4): PUSH 0x11, 0x22, 0x33, 0x44. Required: full=1, tos=0x44, nos=0x33. Then POP ×4 gives tos 0x33, 0x22, 0x11, then empty=1 with tos=0.
- Overflow: a fifth PUSH 0x55 on a full stack. Required: overflow=1, count=4, tos=0x44. CLRERR then gives overflow=0 with the stack intact.
- Underflow: POP on empty, then POP2PUSH with count=1. Required: underflow=1 and count unchanged (0, then 1). tos is unchanged by the failed POP2PUSH.
- ALU flow: PUSH 3, PUSH 5, then POP2PUSH with din=8 (nos+tos). Required: count=1, tos=8, nos=0. Then DUP gives count=2, tos=8, nos=8.
- SWAP/FLUSH: PUSH 0xA, PUSH 0xB, SWAP. Required: tos=0xA, nos=0xB. FLUSH then gives count=0 with the flags unchanged. Repeat with DEPTH=2 and DATA_W=16 to cover the full-stack boundaries.

Source files
------------

// File: rtl/sbmips_pkg.sv
// Shared definitions for the stack-machine core: opcode encoding and default datapath width.
package sbmips_pkg;

    // Default operand width, shared between the operand stack and the datapath.
    parameter int unsigned DefaultDataW = 8;

    typedef enum logic [2:0] {
        OpNop      = 3'd0,
        OpPush     = 3'd1,
        OpPop      = 3'd2,
        OpPop2Push = 3'd3,
        OpDup      = 3'd4,
        OpSwap     = 3'd5,
        OpFlush    = 3'd6,
        OpClrErr   = 3'd7
    } stack_op_t;

endpackage

// File: rtl/stack_regfile.sv
// Operand stack storage: two asynchronous read ports, two synchronous write ports, no reset.
module stack_regfile #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic [AW-1:0]     rd0_addr_i,
    output logic [DATA_W-1:0] rd0_data_o,
    input  logic [AW-1:0]     rd1_addr_i,
    output logic [DATA_W-1:0] rd1_data_o,
    input  logic              we0_i,
    input  logic [AW-1:0]     wa0_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic              we1_i,
    input  logic [AW-1:0]     wa1_i,
    input  logic [DATA_W-1:0] wd1_i
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rd0_data_o = mem_q[rd0_addr_i];
    assign rd1_data_o = mem_q[rd1_addr_i];

    // Both ports only fire together for SWAP, which always targets two distinct entries.
    always_ff @(posedge clk_i) begin
        if (we0_i) begin
            mem_q[wa0_i] <= wd0_i;
        end
        if (we1_i) begin
            mem_q[wa1_i] <= wd1_i;
        end
    end

endmodule

// File: rtl/sbmips_stack.sv
// Parametrised operand stack: one opcode per cycle, zero-latency TOS/NOS, sticky error flags.
module sbmips_stack
    import sbmips_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] tos_o,
    output logic [DATA_W-1:0] nos_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    stack_op_t         op;
    logic [CNT_W-1:0]  sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              has1, has2, is_full;
    logic [AW-1:0]     addr_top, addr_nxt, addr_new;
    logic [DATA_W-1:0] top_raw, nxt_raw;
    logic              we0, we1;
    logic [AW-1:0]     wa0, wa1;
    logic [DATA_W-1:0] wd0, wd1;

    assign op       = stack_op_t'(op_i);
    assign has1     = (sp_q != '0);
    assign has2     = (sp_q >= CNT_W'(2));
    assign is_full  = (sp_q == CNT_W'(DEPTH));

    // Addresses wrap modulo DEPTH; entries they reach when invalid are gated off below.
    assign addr_new = sp_q[AW-1:0];
    assign addr_top = sp_q[AW-1:0] - AW'(1);
    assign addr_nxt = sp_q[AW-1:0] - AW'(2);

    stack_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_regfile (
        .clk_i      (clk_i),
        .rd0_addr_i (addr_top),
        .rd0_data_o (top_raw),
        .rd1_addr_i (addr_nxt),
        .rd1_data_o (nxt_raw),
        .we0_i      (we0),
        .wa0_i      (wa0),
        .wd0_i      (wd0),
        .we1_i      (we1),
        .wa1_i      (wa1),
        .wd1_i      (wd1)
    );

    // Precondition decode: legal ops update sp/storage, illegal ones only raise a flag.
    always_comb begin
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        we0   = 1'b0;
        wa0   = addr_new;
        wd0   = din_i;
        we1   = 1'b0;
        wa1   = addr_nxt;
        wd1   = top_raw;
        unique case (op)
            OpPush: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    we0  = 1'b1;
                    sp_d = sp_q + CNT_W'(1);
                end
            end
            OpPop: begin
                if (!has1) begin
                    unf_d = 1'b1;
                end else begin
                    sp_d = sp_q - CNT_W'(1);
                end
            end
            OpPop2Push: begin
                if (!has2) begin
                    unf_d = 1'b1;
                end else begin
                    we0  = 1'b1;
                    wa0  = addr_nxt;
                    sp_d = sp_q - CNT_W'(1);
                end
            end
            OpDup: begin
                if (!has1) begin
                    unf_d = 1'b1;
                end else if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    we0  = 1'b1;
                    wd0  = top_raw;
                    sp_d = sp_q + CNT_W'(1);
                end
            end
            OpSwap: begin
                if (!has2) begin
                    unf_d = 1'b1;
                end else begin
                    we0 = 1'b1;
                    wa0 = addr_top;
                    wd0 = nxt_raw;
                    we1 = 1'b1;
                end
            end
            OpFlush: begin
                sp_d = '0;
            end
            OpClrErr: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            default: begin
                // OpNop: hold state.
            end
        endcase
    end

    // Stack pointer and sticky flags; reset discards any op in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage is never reset, so invalid entries are forced to zero on the outputs.
    always_comb begin
        tos_o       = has1 ? top_raw : '0;
        nos_o       = has2 ? nxt_raw : '0;
        count_o     = sp_q;
        empty_o     = !has1;
        full_o      = is_full;
        overflow_o  = ovf_q;
        underflow_o = unf_q;
    end

endmodule
